l1_mem_wr_sched: RTL and testbench
==================================

# l1_mem_wr_sched

Write-port scheduler for an L1 register-based data/tag array (asynchronous read, synchronous write, one write per cycle). It shares the array's single write port between two requesters: core store (A) and refill (B). Arbitration is round-robin. It also sequences a whole-array flush that writes zero to every entry. It sits between the L1 control logic and the array's `wen/waddr/wdata` pins; reads bypass it.

## Interface
- `WIDTH`, 32, entry width in bits
- `DEPTH`, 1024, number of entries, ≥2; `AW = $clog2(DEPTH)`

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `a_req`  in  1  store write request; level, held until `a_ack`
- `a_addr`  in  AW  store write address
- `a_data`  in  WIDTH  store write data
- `a_ack`  out  1  store request accepted this cycle
- `b_req`  in  1  refill write request; level, held until `b_ack`
- `b_addr`  in  AW  refill write address
- `b_data`  in  WIDTH  refill write data
- `b_ack`  out  1  refill request accepted this cycle
- `flush_req`  in  1  start flush; sampled only in IDLE
- `flush_busy`  out  1  flush in progress (FLUSH or DONE state)
- `flush_done`  out  1  one-cycle pulse on the final flush write
- `mem_wen`  out  1  array write enable, registered
- `mem_waddr`  out  AW  array write address, registered
- `mem_wdata`  out  WIDTH  array write data, registered

## Operation
- States: IDLE, FLUSH, DONE.
- IDLE, `flush_req`=1:
  - Go to FLUSH and clear `cnt` to 0.
  - No ack this cycle, even when `a_req`/`b_req` are also high. Flush has priority.
- IDLE, no flush:
  - Grant one requester with a combinational ack in the same cycle.
  - Register its addr/data onto `mem_*` with `mem_wen`=1 for the next cycle.
  - If no grant, `mem_wen`=0 next cycle.
- Round-robin uses a 1-bit `prio` (0 = A preferred, 1 = B preferred).
  - Both requesting: grant the preferred side.
  - One requesting: grant it regardless of `prio`.
  - After every grant, `prio` points to the other side.
- FLUSH:
  - Each cycle register `mem_wen`=1, `mem_waddr`=`cnt`, `mem_wdata`=0, then `cnt`++.
  - When `cnt`==DEPTH-1 is issued, go to DONE.
  - Acks held 0. `flush_req` is ignored.
- DONE:
  - `flush_done`=1, acks 0, `cnt` cleared.
  - Next state IDLE. `prio` is unchanged by the flush.
- `cnt` is AW bits. The terminal compare is against DEPTH-1, so non-power-of-two DEPTH never wraps past the last entry.
- `flush_busy` = (state != IDLE). `flush_done` is registered, decoded from state DONE.
- Acks depend only on state, `prio`, and req inputs, never on addr/data.
- The block never issues two writes in one cycle. The output is exactly one source per cycle.

## Timing
- Reset (async, any state, including mid-flush):
  - state IDLE, `cnt`=0, `prio`=0.
  - `mem_wen`=0, `mem_waddr`=0, `mem_wdata`=0.
  - `flush_busy`=0, `flush_done`=0, `a_ack`=`b_ack`=0.
  - An interrupted flush is abandoned, not resumed.
- Write latency: request acked in cycle N → array write at the posedge ending cycle N+1.
  - A read of that address returns new data from cycle N+2.
- Back-to-back:
  - A requester holding `req` after ack is treated as a new request and may be acked every cycle.
  - When both are held, grants strictly alternate.
- Flush, `flush_req` in IDLE at cycle N:
  - `flush_busy`=1 from N+1 through N+1+DEPTH.
  - Address k is on `mem_*` at cycle N+2+k.
  - `flush_done`=1 at cycle N+1+DEPTH, coincident with the address DEPTH-1 write.
  - IDLE and first ack possible at N+2+DEPTH.
- Requests pending during a flush stay pending. They arbitrate normally from N+2+DEPTH.

## Structure
- Shared package `l1_pkg`:
  - `typedef enum logic [1:0] {WS_IDLE, WS_FLUSH, WS_DONE} l1_wsched_state_t`
  - Requester index constants `L1_WREQ_STORE`=0, `L1_WREQ_REFILL`=1.
- Sub-module `l1_rr_arb2`:
  - 2-input round-robin arbiter with `prio` register, `req[1:0]` in, one-hot `gnt[1:0]` out, `en` input to freeze during flush.
  - Reused by other L1 shared resources.
- Scheduler top: FSM, `cnt`, output register stage.

## Test plan
- Single A write:
  - Stimulus: `a_req`=1, `a_addr`=5, `a_data`=0xDEADBEEF at cycle N.
  - Response: `a_ack`=1 at N. `mem_wen`/addr 5/data 0xDEADBEEF at N+1. Array readback 0xDEADBEEF at N+2.
- Contention:
  - Stimulus: A (addr 1, 0x11) and B (addr 2, 0x22) both held from reset.
  - Response: acks A,B,A,B… alternate. First write addr 1, second addr 2. `prio` toggles each grant.
- Flush, DEPTH=8, array preloaded 0xFF..:
  - Stimulus: `flush_req` at N.
  - Response: `mem_waddr` 0..7 with data 0 at N+2..N+9. `flush_done` only at N+9. `flush_busy` N+1..N+9. All entries read 0 at N+10.
- Flush vs request:
  - Stimulus: `flush_req` and `b_req` in the same IDLE cycle.
  - Response: no `b_ack` until N+10 (DEPTH=8). B's write lands after the last zero write, not overwritten.
- Reset mid-flush:
  - Stimulus: `rst_n` low at flush address 3.
  - Response: all outputs 0 immediately. No `flush_done`. After release, `a_req` is acked in the first cycle.

Source files
------------

// File: rtl/l1_pkg.sv
// Shared L1 definitions: write-scheduler state encoding and requester indices.
package l1_pkg;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_FLUSH,
        WS_DONE
    } l1_wsched_state_t;

    localparam int L1_WREQ_STORE  = 0;
    localparam int L1_WREQ_REFILL = 1;

endpackage

// File: rtl/l1_rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer flips after every grant
// and is frozen while i_en is low.
module l1_rr_arb2
    import l1_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_prio;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt[L1_WREQ_STORE]  = ~r_prio;
                o_gnt[L1_WREQ_REFILL] = r_prio;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // After a store grant, prefer refill next time, and vice versa.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio <= 1'b0;
        end else if (i_en && (o_gnt != 2'b00)) begin
            r_prio <= o_gnt[L1_WREQ_STORE];
        end
    end

endmodule

// File: rtl/l1_mem_wr_sched.sv
// L1 array write-port scheduler: round-robin store/refill arbitration plus a
// whole-array zero flush, driving a registered wen/waddr/wdata stage.
//
// state    | meaning
// WS_IDLE  | arbitrate store/refill, or start a flush on i_flush_req
// WS_FLUSH | write zero to entry r_cnt each cycle, up to DEPTH-1
// WS_DONE  | last zero write visible on mem_*, pulse flush_done
module l1_mem_wr_sched
    import l1_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_a_req,
    input  logic [AW-1:0]    i_a_addr,
    input  logic [WIDTH-1:0] i_a_data,
    output logic             o_a_ack,
    input  logic             i_b_req,
    input  logic [AW-1:0]    i_b_addr,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_b_ack,
    input  logic             i_flush_req,
    output logic             o_flush_busy,
    output logic             o_flush_done,
    output logic             o_mem_wen,
    output logic [AW-1:0]    o_mem_waddr,
    output logic [WIDTH-1:0] o_mem_wdata
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    l1_wsched_state_t r_state;
    l1_wsched_state_t w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic             w_arb_en;
    logic [1:0]       w_gnt;

    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = 1'b0;
        case (r_state)
            WS_IDLE: begin
                if (i_flush_req) begin
                    w_state_nxt = WS_FLUSH;
                end else begin
                    // Reset gating keeps acks low while rst_n is asserted.
                    w_arb_en = i_rst_n;
                end
            end
            WS_FLUSH: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = WS_DONE;
                end
            end
            WS_DONE:  w_state_nxt = WS_IDLE;
            default:  w_state_nxt = WS_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == WS_FLUSH) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    l1_rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_arb_en),
        .i_req   ({i_b_req, i_a_req}),
        .o_gnt   (w_gnt)
    );

    assign o_a_ack = w_gnt[L1_WREQ_STORE];
    assign o_b_ack = w_gnt[L1_WREQ_REFILL];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_wen   <= 1'b0;
            o_mem_waddr <= '0;
            o_mem_wdata <= '0;
        end else if (r_state == WS_FLUSH) begin
            o_mem_wen   <= 1'b1;
            o_mem_waddr <= r_cnt;
            o_mem_wdata <= '0;
        end else if (w_gnt[L1_WREQ_STORE]) begin
            o_mem_wen   <= 1'b1;
            o_mem_waddr <= i_a_addr;
            o_mem_wdata <= i_a_data;
        end else if (w_gnt[L1_WREQ_REFILL]) begin
            o_mem_wen   <= 1'b1;
            o_mem_waddr <= i_b_addr;
            o_mem_wdata <= i_b_data;
        end else begin
            o_mem_wen   <= 1'b0;
        end
    end

    assign o_flush_busy = (r_state != WS_IDLE);
    assign o_flush_done = (r_state == WS_DONE);

endmodule

// File: tb/tb_l1_mem_wr_sched.sv
// Randomized bench for l1_mem_wr_sched (DEPTH=8) against a queue-based
// reference of grants and flush write schedules.
module tb_l1_mem_wr_sched;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_req, b_req, flush_req;
    logic [AW-1:0]    a_addr, b_addr;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ack, b_ack, flush_busy, flush_done;
    logic             mem_wen;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    l1_mem_wr_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_a_req      (a_req),
        .i_a_addr     (a_addr),
        .i_a_data     (a_data),
        .o_a_ack      (a_ack),
        .i_b_req      (b_req),
        .i_b_addr     (b_addr),
        .i_b_data     (b_data),
        .o_b_ack      (b_ack),
        .i_flush_req  (flush_req),
        .o_flush_busy (flush_busy),
        .o_flush_done (flush_done),
        .o_mem_wen    (mem_wen),
        .o_mem_waddr  (mem_waddr),
        .o_mem_wdata  (mem_wdata)
    );

    // Array behind the write port, as seen by readers.
    logic [WIDTH-1:0] arr [DEPTH];
    always @(posedge clk) if (mem_wen) arr[mem_waddr] <= mem_wdata;

    // Reference state: each queued entry is one future busy cycle.
    typedef struct {
        bit done;
        int addr;
    } fl_t;
    fl_t              q[$];
    bit               m_prio;
    logic [WIDTH-1:0] m_arr [DEPTH];
    logic             e_wen;
    logic [AW-1:0]    e_addr;
    logic [WIDTH-1:0] e_data;
    logic             seen_a, seen_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prio = 1'b0;
        e_wen  = 1'b0;
        e_addr = '0;
        e_data = '0;
    endtask

    task automatic step();
        logic ea, eb, nwen;
        logic [AW-1:0] naddr;
        logic [WIDTH-1:0] ndata;
        fl_t f;
        @(negedge clk);
        ea = 0; eb = 0; nwen = 0; naddr = e_addr; ndata = e_data;
        if (q.size() > 0) begin
            f = q.pop_front();
            check("busy", flush_busy, 1);
            check("done", flush_done, f.done);
            if (!f.done) begin
                nwen = 1; naddr = AW'(f.addr); ndata = '0;
            end
        end else begin
            check("busy_idle", flush_busy, 0);
            check("done_idle", flush_done, 0);
            if (flush_req) begin
                for (int k = 0; k < DEPTH; k++) q.push_back('{done: 1'b0, addr: k});
                q.push_back('{done: 1'b1, addr: 0});
            end else if (a_req && b_req) begin
                if (m_prio) eb = 1; else ea = 1;
            end else begin
                ea = a_req;
                eb = b_req;
            end
            if (ea) begin nwen = 1; naddr = a_addr; ndata = a_data; m_prio = 1'b1; end
            if (eb) begin nwen = 1; naddr = b_addr; ndata = b_data; m_prio = 1'b0; end
        end
        check("a_ack", a_ack, ea);
        check("b_ack", b_ack, eb);
        check("mem_wen", mem_wen, e_wen);
        if (e_wen) begin
            check("mem_waddr", mem_waddr, e_addr);
            check("mem_wdata", mem_wdata, e_data);
            m_arr[e_addr] = e_data;
        end
        seen_a = a_ack;
        seen_b = b_ack;
        e_wen = nwen; e_addr = naddr; e_data = ndata;
        @(posedge clk);
        #1;
    endtask

    task automatic check_arr(input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, arr[i], m_arr[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 0; b_req = 0; flush_req = 0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        model_reset();
        #12;
        check("rst_wen", mem_wen, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", flush_busy, 0);
        check("rst_done", flush_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention from reset: A first, then strict alternation.
        a_req = 1; a_addr = 3'd1; a_data = 32'h11;
        b_req = 1; b_addr = 3'd2; b_data = 32'h22;
        for (int i = 0; i < 6; i++) step();
        a_req = 0; b_req = 0;
        step();

        // Preload every entry with all-ones.
        for (int i = 0; i < DEPTH; i++) begin
            a_req = 1; a_addr = AW'(i); a_data = 32'hFFFF_FFFF;
            step();
        end
        a_req = 0;
        step(); step();
        check_arr("preload");

        // Single store write and readback two cycles later.
        a_req = 1; a_addr = 3'd5; a_data = 32'hDEAD_BEEF;
        step();
        a_req = 0;
        step(); step();
        check("rdback5", arr[5], 32'hDEAD_BEEF);

        // Flush with a simultaneous refill request held throughout.
        flush_req = 1; b_req = 1; b_addr = 3'd6; b_data = 32'hCAFE_0006;
        step();
        flush_req = 0;
        for (int i = 0; i < 20 && !seen_b; i++) step();
        check("b_acked", seen_b, 1);
        b_req = 0;
        step(); step();
        check_arr("flush_b");
        check("b_survives", arr[6], 32'hCAFE_0006);

        // Randomized traffic with occasional flush pulses.
        for (int c = 0; c < 400; c++) begin
            if (!a_req || seen_a) begin
                a_req  = ($urandom_range(0, 2) != 0);
                a_addr = AW'($urandom_range(0, DEPTH - 1));
                a_data = $urandom;
            end
            if (!b_req || seen_b) begin
                b_req  = ($urandom_range(0, 2) != 0);
                b_addr = AW'($urandom_range(0, DEPTH - 1));
                b_data = $urandom;
            end
            flush_req = ($urandom_range(0, 29) == 0);
            step();
        end
        a_req = 0; b_req = 0; flush_req = 0;
        for (int i = 0; i < 12; i++) step();
        check_arr("random");

        // Reset while address 3 of a flush is on the write port.
        flush_req = 1;
        step();
        flush_req = 0;
        for (int i = 0; i < 20 && !(e_wen && e_addr == 3'd3 && q.size() > 0); i++) step();
        check("reached_addr3", e_wen && e_addr == 3'd3, 1);
        a_req = 1; a_addr = 3'd4; a_data = 32'h0BAD_F00D;
        rst_n = 1'b0;
        #1;
        check("mid_wen", mem_wen, 0);
        check("mid_waddr", mem_waddr, 0);
        check("mid_wdata", mem_wdata, 0);
        check("mid_busy", flush_busy, 0);
        check("mid_done", flush_done, 0);
        check("mid_a_ack", a_ack, 0);
        check("mid_b_ack", b_ack, 0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_hold_done", flush_done, 0);
            check("rst_hold_ack", a_ack, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        check("post_rst_ack", seen_a, 1);
        a_req = 0;
        for (int i = 0; i < 12; i++) step();
        check_arr("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
